// File: rtl/sq_sum_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : sq_sum_bcd
//  Description : Accumulates FRAME consecutive 6-bit squares into a saturating
//                12-bit sum. The sum is then converted to 4-digit BCD with a
//                sequential shift-add-3 (double-dabble) engine, and the result
//                is held for a consumer under a valid/ready handshake.
//
//  Ports
//    clk        in   rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    sq_in      in   [5:0]  unsigned square from the squarer stage
//    sq_valid   in   sq_in is valid this cycle
//    sq_ready   out  block can accept a square this cycle
//    sum_out    out  [11:0] binary frame sum, saturated at 4095
//    bcd_out    out  [15:0] sum_out as BCD; [15:12] thousands, [3:0] units
//    ovf        out  frame sum exceeded 4095 (sum_out saturated)
//    out_valid  out  sum_out / bcd_out / ovf are valid and stable
//    out_ready  in   consumer takes the result this cycle
//
//  Revision    : 1.0  initial release
// ============================================================================
module sq_sum_bcd #(
    parameter int FRAME = 8            // squares per result, 1..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  sq_in,
    input  logic        sq_valid,
    output logic        sq_ready,
    output logic [11:0] sum_out,
    output logic [15:0] bcd_out,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] c_ACCUM   = 2'd0;
    localparam logic [1:0] c_CONVERT = 2'd1;
    localparam logic [1:0] c_HOLD    = 2'd2;

    localparam logic [7:0] c_LAST      = 8'(FRAME - 1);
    localparam logic [3:0] c_LAST_STEP = 4'd11;   // 12 steps: 0..11

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        w_sq_ready;

    logic [12:0] r_acc;
    logic [7:0]  r_cnt;
    logic        r_ovf_int;
    logic [3:0]  r_step;
    logic [27:0] r_shift;          // {bcd[15:0], bin[11:0]}
    logic [11:0] r_sum_out;
    logic [15:0] r_bcd_out;
    logic        r_ovf;
    logic        r_out_valid;

    logic        w_accept;
    logic        w_final;
    logic [12:0] w_sum;
    logic [11:0] w_sat;
    logic [15:0] w_bcd_adj;
    logic [27:0] w_shift_next;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ACCUM:   if (w_final)                    w_state_next = c_CONVERT;
            c_CONVERT: if (r_step == c_LAST_STEP)      w_state_next = c_HOLD;
            c_HOLD:    if (r_out_valid && out_ready)   w_state_next = c_ACCUM;
            default:                                   w_state_next = c_ACCUM;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (registered state only, no input paths)
    // ------------------------------------------------------------------
    always_comb begin
        w_sq_ready = 1'b0;
        if (r_state == c_ACCUM) begin
            w_sq_ready = 1'b1;
        end
    end

    assign sq_ready = w_sq_ready;

    // ------------------------------------------------------------------
    // Accumulate with saturation. r_acc never exceeds 4095, so the
    // 13-bit sum cannot wrap and bit 12 flags a true overflow.
    // ------------------------------------------------------------------
    assign w_accept = sq_valid && w_sq_ready;
    assign w_final  = w_accept && (r_cnt == c_LAST);
    assign w_sum    = r_acc + {7'd0, sq_in};
    assign w_sat    = w_sum[12] ? 12'hFFF : w_sum[11:0];

    // ------------------------------------------------------------------
    // Double-dabble step: add 3 to every BCD digit >= 5, then shift the
    // whole {bcd, bin} register left by one.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [3:0] w_d;
        assign w_d = r_shift[12 + 4*gi +: 4];
        assign w_bcd_adj[4*gi +: 4] = (w_d >= 4'd5) ? (w_d + 4'd3) : w_d;
    end

    assign w_shift_next = {w_bcd_adj[14:0], r_shift[11:0], 1'b0};

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= 13'd0;
            r_cnt       <= 8'd0;
            r_ovf_int   <= 1'b0;
            r_step      <= 4'd0;
            r_shift     <= 28'd0;
            r_sum_out   <= 12'd0;
            r_bcd_out   <= 16'd0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ACCUM: begin
                    if (w_accept) begin
                        r_acc     <= {1'b0, w_sat};
                        r_ovf_int <= r_ovf_int | w_sum[12];
                        r_cnt     <= r_cnt + 8'd1;
                        if (w_final) begin
                            r_sum_out <= w_sat;
                            r_shift   <= {16'd0, w_sat};
                            r_cnt     <= 8'd0;
                            r_step    <= 4'd0;
                        end
                    end
                end
                c_CONVERT: begin
                    r_shift <= w_shift_next;
                    r_step  <= r_step + 4'd1;
                    if (r_step == c_LAST_STEP) begin
                        r_bcd_out   <= w_shift_next[27:12];
                        r_ovf       <= r_ovf_int;
                        r_out_valid <= 1'b1;
                        r_step      <= 4'd0;
                    end
                end
                c_HOLD: begin
                    // Held results stay put; new squares are ignored here.
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= 13'd0;
                        r_cnt       <= 8'd0;
                        r_ovf_int   <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign sum_out   = r_sum_out;
    assign bcd_out   = r_bcd_out;
    assign ovf       = r_ovf;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
